// File: rtl/sourcea_beat_queue_pkg.sv
// Shared definitions for the buffered A-channel source: TileLink opcodes,
// default field widths and a small opcode classification helper.
package sourcea_beat_queue_pkg;

    // TileLink A-channel opcodes used by the L2 side
    typedef enum logic [2:0] {
        TL_PUT_FULL    = 3'd0,
        TL_PUT_PARTIAL = 3'd1,
        TL_GET         = 3'd4
    } tl_a_opcode_e;

    // Default field widths
    localparam int TAG_W_DEF     = 20;
    localparam int SET_W_DEF     = 6;
    localparam int OFFSET_W_DEF  = 6;
    localparam int OP_W_DEF      = 3;
    localparam int SIZE_W_DEF    = 3;
    localparam int SOURCE_W_DEF  = 8;
    localparam int LINE_BITS_DEF = 512;
    localparam int BEAT_BITS_DEF = 128;
    localparam int DEPTH_DEF     = 4;

    // Only the two Put flavours carry a multi-beat payload; everything else
    // (Get and any unknown opcode) is a single-beat message.
    function automatic logic is_burst_op(input logic [2:0] op);
        return (op == TL_PUT_FULL) || (op == TL_PUT_PARTIAL);
    endfunction

endpackage

// File: rtl/sourcea_beat_queue_sync_fifo_ptr.sv
// Generic DEPTH x WIDTH register FIFO with read/write pointers and an
// occupancy counter. Read data is the head entry, available without a pop.
module sync_fifo_ptr #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_en_s;
    logic             pop_en_s;

    assign full      = (count_r == (PTR_W + 1)'(DEPTH));
    assign empty     = (count_r == {(PTR_W + 1){1'b0}});
    assign push_en_s = push && !full;
    assign pop_en_s  = pop && !empty;
    assign rd_data   = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
            end
            case ({push_en_s, pop_en_s})
                2'b10:   count_r <= count_r + {{PTR_W{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{PTR_W{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_en_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/sourcea_beat_queue.sv
// Buffered A-channel source: queues full-line L2 requests and serialises
// Put payloads into BEAT_BITS-wide beats on a TileLink-style A channel.
module sourcea_beat_queue
    import sourcea_beat_queue_pkg::*;
#(
    parameter int TAG_W     = TAG_W_DEF,
    parameter int SET_W     = SET_W_DEF,
    parameter int OFFSET_W  = OFFSET_W_DEF,
    parameter int OP_W      = OP_W_DEF,
    parameter int SIZE_W    = SIZE_W_DEF,
    parameter int SOURCE_W  = SOURCE_W_DEF,
    parameter int LINE_BITS = LINE_BITS_DEF,
    parameter int BEAT_BITS = BEAT_BITS_DEF,
    parameter int DEPTH     = DEPTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [SET_W-1:0]                  req_set_i,
    input  logic [TAG_W-1:0]                  req_tag_i,
    input  logic [OFFSET_W-1:0]               req_offset_i,
    input  logic [OP_W-1:0]                   req_opcode_i,
    input  logic [SIZE_W-1:0]                 req_size_i,
    input  logic [SOURCE_W-1:0]               req_source_i,
    input  logic [LINE_BITS-1:0]              req_data_i,
    input  logic [LINE_BITS/8-1:0]            req_mask_i,
    output logic                              a_valid_o,
    input  logic                              a_ready_i,
    output logic [OP_W-1:0]                   a_opcode_o,
    output logic [SIZE_W-1:0]                 a_size_o,
    output logic [SOURCE_W-1:0]               a_source_o,
    output logic [TAG_W+SET_W+OFFSET_W-1:0]   a_address_o,
    output logic [BEAT_BITS/8-1:0]            a_mask_o,
    output logic [BEAT_BITS-1:0]              a_data_o,
    output logic [2:0]                        a_param_o,
    output logic [$clog2(DEPTH):0]            count_o
);

    localparam int ADDR_W   = TAG_W + SET_W + OFFSET_W;
    localparam int MASK_W   = LINE_BITS / 8;
    localparam int BMASK_W  = BEAT_BITS / 8;
    localparam int BEATS    = LINE_BITS / BEAT_BITS;
    localparam int BC_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ENTRY_W  = OP_W + SIZE_W + SOURCE_W + ADDR_W + MASK_W + LINE_BITS;

    logic [ENTRY_W-1:0]   push_entry_s;
    logic [ENTRY_W-1:0]   head_entry_s;
    logic [OP_W-1:0]      head_op_s;
    logic [SIZE_W-1:0]    head_size_s;
    logic [SOURCE_W-1:0]  head_source_s;
    logic [ADDR_W-1:0]    head_addr_s;
    logic [MASK_W-1:0]    head_mask_s;
    logic [LINE_BITS-1:0] head_data_s;
    logic                 full_s;
    logic                 empty_s;
    logic                 burst_s;
    logic                 last_beat_s;
    logic                 fire_s;
    logic                 pop_s;
    logic [BC_W-1:0]      beat_r;
    logic [BC_W-1:0]      beat_sel_s;

    // The memory address is composed once at enqueue time as {tag,set,offset}
    assign push_entry_s = {req_opcode_i, req_size_i, req_source_i,
                           req_tag_i, req_set_i, req_offset_i,
                           req_mask_i, req_data_i};

    assign {head_op_s, head_size_s, head_source_s,
            head_addr_s, head_mask_s, head_data_s} = head_entry_s;

    sync_fifo_ptr #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (req_valid_i),
        .pop     (pop_s),
        .wr_data (push_entry_s),
        .rd_data (head_entry_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (count_o)
    );

    // Readiness depends only on occupancy: a full queue stays not-ready even
    // when the head's last beat leaves in the same cycle.
    assign req_ready_o = !full_s;
    assign a_valid_o   = !empty_s;
    assign fire_s      = a_valid_o && a_ready_i;
    assign burst_s     = is_burst_op(3'(head_op_s));
    assign last_beat_s = !burst_s || (beat_r == BC_W'(BEATS - 1));
    assign pop_s       = fire_s && last_beat_s;

    assign a_opcode_o  = head_op_s;
    assign a_size_o    = head_size_s;
    assign a_source_o  = head_source_s;
    assign a_address_o = head_addr_s;
    assign a_param_o   = 3'b000;

    // Beat slice selection: single-beat messages always use the beat-0 slice,
    // and Get carries no data at all.
    always_comb begin
        beat_sel_s = {BC_W{1'b0}};
        a_data_o   = {BEAT_BITS{1'b0}};
        a_mask_o   = {BMASK_W{1'b0}};
        if (burst_s) begin
            beat_sel_s = beat_r;
        end else begin
            beat_sel_s = {BC_W{1'b0}};
        end
        a_mask_o = head_mask_s[int'(beat_sel_s) * BMASK_W +: BMASK_W];
        if (head_op_s == OP_W'(TL_GET)) begin
            a_data_o = {BEAT_BITS{1'b0}};
        end else begin
            a_data_o = head_data_s[int'(beat_sel_s) * BEAT_BITS +: BEAT_BITS];
        end
    end

    // Beat counter: advances on each accepted non-final beat, clears on the last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_r <= {BC_W{1'b0}};
        end else if (fire_s) begin
            if (last_beat_s) begin
                beat_r <= {BC_W{1'b0}};
            end else begin
                beat_r <= beat_r + {{(BC_W - 1){1'b0}}, 1'b1};
            end
        end else begin
            beat_r <= beat_r;
        end
    end

endmodule

// File: tb/tb_sourcea_beat_queue.sv
// Self-checking bench for sourcea_beat_queue: directed scenarios followed by
// randomized traffic, all checked against a request-level queue model.
module tb_sourcea_beat_queue;

    logic           clk;
    logic           rst;
    logic           req_valid_i;
    logic           req_ready_o;
    logic [5:0]     req_set_i;
    logic [19:0]    req_tag_i;
    logic [5:0]     req_offset_i;
    logic [2:0]     req_opcode_i;
    logic [2:0]     req_size_i;
    logic [7:0]     req_source_i;
    logic [511:0]   req_data_i;
    logic [63:0]    req_mask_i;
    logic           a_valid_o;
    logic           a_ready_i;
    logic [2:0]     a_opcode_o;
    logic [2:0]     a_size_o;
    logic [7:0]     a_source_o;
    logic [31:0]    a_address_o;
    logic [15:0]    a_mask_o;
    logic [127:0]   a_data_o;
    logic [2:0]     a_param_o;
    logic [2:0]     count_o;

    sourcea_beat_queue dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_set_i    (req_set_i),
        .req_tag_i    (req_tag_i),
        .req_offset_i (req_offset_i),
        .req_opcode_i (req_opcode_i),
        .req_size_i   (req_size_i),
        .req_source_i (req_source_i),
        .req_data_i   (req_data_i),
        .req_mask_i   (req_mask_i),
        .a_valid_o    (a_valid_o),
        .a_ready_i    (a_ready_i),
        .a_opcode_o   (a_opcode_o),
        .a_size_o     (a_size_o),
        .a_source_o   (a_source_o),
        .a_address_o  (a_address_o),
        .a_mask_o     (a_mask_o),
        .a_data_o     (a_data_o),
        .a_param_o    (a_param_o),
        .count_o      (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [2:0]   size;
        logic [7:0]   src;
        logic [31:0]  addr;
        logic [511:0] data;
        logic [63:0]  mask;
    } req_t;

    req_t mq[$];
    int   head_beat;
    int   compared;
    int   mismatched;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Puts carry four 128-bit beats of a 512-bit line; everything else is one beat
    function automatic int beats_of(input logic [2:0] op);
        return (op == 3'd0 || op == 3'd1) ? 4 : 1;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [63:0] rand_mask();
        return {$urandom, $urandom};
    endfunction

    task automatic check_outputs();
        req_t         h;
        logic [511:0] dsh;
        logic [63:0]  msh;
        logic [127:0] exp_data;
        chk("a_valid", {511'd0, a_valid_o}, {511'd0, mq.size() != 0});
        chk("req_ready", {511'd0, req_ready_o}, {511'd0, mq.size() < 4});
        chk("count", {509'd0, count_o}, 512'(mq.size()));
        chk("a_param", {509'd0, a_param_o}, 512'd0);
        if (mq.size() != 0) begin
            h   = mq[0];
            dsh = h.data >> (head_beat * 128);
            msh = h.mask >> (head_beat * 16);
            exp_data = (h.op == 3'd4) ? 128'd0 : dsh[127:0];
            chk("a_opcode", {509'd0, a_opcode_o}, {509'd0, h.op});
            chk("a_size", {509'd0, a_size_o}, {509'd0, h.size});
            chk("a_source", {504'd0, a_source_o}, {504'd0, h.src});
            chk("a_address", {480'd0, a_address_o}, {480'd0, h.addr});
            chk("a_mask", {496'd0, a_mask_o}, {496'd0, msh[15:0]});
            chk("a_data", {384'd0, a_data_o}, {384'd0, exp_data});
        end
    endtask

    // One clock cycle: inputs were driven at the preceding negedge
    task automatic tick();
        logic do_push;
        logic do_fire;
        req_t r;
        #1;
        check_outputs();
        do_push = req_valid_i && (mq.size() < 4);
        do_fire = (mq.size() != 0) && a_ready_i;
        r.op   = req_opcode_i;
        r.size = req_size_i;
        r.src  = req_source_i;
        r.addr = {req_tag_i, req_set_i, req_offset_i};
        r.data = req_data_i;
        r.mask = req_mask_i;
        @(posedge clk);
        if (do_fire) begin
            if (head_beat == beats_of(mq[0].op) - 1) begin
                void'(mq.pop_front());
                head_beat = 0;
            end else begin
                head_beat++;
            end
        end
        if (do_push) mq.push_back(r);
        @(negedge clk);
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [19:0] tag, input logic [5:0] set,
                             input logic [5:0] off, input logic [7:0] src, input logic [2:0] size,
                             input logic [511:0] data, input logic [63:0] mask);
        req_valid_i  = 1'b1;
        req_opcode_i = op;
        req_tag_i    = tag;
        req_set_i    = set;
        req_offset_i = off;
        req_source_i = src;
        req_size_i   = size;
        req_data_i   = data;
        req_mask_i   = mask;
    endtask

    task automatic drive_rand_put();
        drive_req(3'($urandom_range(0, 1)), 20'($urandom), 6'($urandom), 6'($urandom),
                  8'($urandom), 3'd6, rand_line(), rand_mask());
    endtask

    initial begin
        logic [511:0] line;
        logic [2:0]   ops [8];
        compared   = 0;
        mismatched = 0;
        head_beat  = 0;
        ops = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd0, 3'd2, 3'd5, 3'd7};
        rst = 1'b1;
        a_ready_i = 1'b0;
        drive_req(3'd0, 20'd0, 6'd0, 6'd0, 8'd0, 3'd0, 512'd0, 64'd0);
        req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_a_valid", {511'd0, a_valid_o}, 512'd0);
        chk("rst_req_ready", {511'd0, req_ready_o}, 512'd1);
        chk("rst_count", {509'd0, count_o}, 512'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single Get: visible one cycle after push, for exactly one cycle
        a_ready_i = 1'b1;
        drive_req(3'd4, 20'h12345, 6'h3, 6'h0, 8'd7, 3'd6, rand_line(), 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        req_valid_i = 1'b0;
        #1;
        chk("get_address", {480'd0, a_address_o}, {480'd0, 32'h123450C0});
        chk("get_opcode", {509'd0, a_opcode_o}, 512'd4);
        chk("get_data", {384'd0, a_data_o}, 512'd0);
        tick();
        tick();

        // PutFullData with distinct beats D0..D3, all-ones mask
        for (int k = 0; k < 4; k++) line[k*128 +: 128] = {4{32'hA000_0000 + 32'(k)}};
        drive_req(3'd0, 20'hABCDE, 6'h15, 6'h0, 8'd3, 3'd6, line, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        req_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("put_beat_data", {384'd0, a_data_o}, {384'd0, {4{32'hA000_0000 + 32'(k)}}});
            chk("put_beat_mask", {496'd0, a_mask_o}, 512'hFFFF);
            tick();
        end
        #1;
        chk("put_drained_count", {509'd0, count_o}, 512'd0);
        tick();

        // Fill to full under back-pressure, then drain 16 beats
        a_ready_i = 1'b0;
        repeat (4) begin
            drive_req(3'd0, 20'($urandom), 6'($urandom), 6'd0, 8'($urandom), 3'd6, rand_line(), rand_mask());
            tick();
        end
        drive_rand_put();
        tick();
        req_valid_i = 1'b0;
        a_ready_i = 1'b1;
        repeat (18) tick();

        // Back-pressure on beat 1 for three cycles
        drive_rand_put();
        tick();
        req_valid_i = 1'b0;
        tick();
        a_ready_i = 1'b0;
        repeat (3) tick();
        a_ready_i = 1'b1;
        repeat (4) tick();

        // Simultaneous push and last-beat pop at count 2
        a_ready_i = 1'b0;
        repeat (2) begin drive_rand_put(); tick(); end
        req_valid_i = 1'b0;
        a_ready_i = 1'b1;
        repeat (3) tick();
        drive_rand_put();
        tick();
        req_valid_i = 1'b0;
        #1;
        chk("pushpop_count", {509'd0, count_o}, 512'd2);
        repeat (10) tick();

        // Reset asserted during beat 2 with two Puts queued
        a_ready_i = 1'b0;
        repeat (2) begin drive_req(3'd0, 20'($urandom), 6'($urandom), 6'd0, 8'd1, 3'd6, rand_line(), rand_mask()); tick(); end
        req_valid_i = 1'b0;
        a_ready_i = 1'b1;
        repeat (2) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_a_valid", {511'd0, a_valid_o}, 512'd0);
        chk("midrst_count", {509'd0, count_o}, 512'd0);
        mq.delete();
        head_beat = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive_req(3'd4, 20'($urandom), 6'($urandom), 6'($urandom), 8'd9, 3'd3, rand_line(), rand_mask());
        tick();
        req_valid_i = 1'b0;
        repeat (2) tick();

        // Randomized traffic including unknown opcodes
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                drive_req(ops[$urandom_range(0, 7)], 20'($urandom), 6'($urandom), 6'($urandom),
                          8'($urandom), 3'($urandom), rand_line(), rand_mask());
            end else begin
                req_valid_i = 1'b0;
            end
            a_ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid_i = 1'b0;
        a_ready_i = 1'b1;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
